// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - burst read engine: sequential wrapped RAM reads presented as a valid/ready stream
// Credits cover reads in flight plus skid FIFO occupancy, so the FIFO can never overflow.
module ram_burst_reader #(
    parameter int WORD_COUNT = 640,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 11,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam logic [CW-1:0]         CREDIT_MAX = CW'(SKID_DEPTH);
    localparam logic [CW-1:0]         CREDIT_ONE = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(WORD_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);
    localparam logic [PW:0]           PTR_ONE    = (PW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [CW-1:0]         credits_q;
    logic [RD_LATENCY-1:0] pipe_valid_q;
    logic [RD_LATENCY-1:0] pipe_last_q;
    logic [RD_LATENCY:0]   pipe_valid_in;
    logic [RD_LATENCY:0]   pipe_last_in;
    logic [DATA_WIDTH-1:0] fifo_data [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] fifo_last_q;
    logic [PW:0]           wr_ptr_q;
    logic [PW:0]           rd_ptr_q;
    logic                  done_q;

    logic idle_ready;
    logic issue;
    logic issue_last;
    logic finish;
    logic accept;
    logic pop;
    logic fill;
    logic fifo_empty;

    // Reset forces every output low combinationally, even before the first reset edge.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign out_valid  = !reset && !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign cmd_ready  = !reset && idle_ready;
    assign accept     = cmd_ready && cmd_valid;
    assign rd_en      = !reset && issue;
    assign rd_addr    = reset ? '0 : (issue ? addr_q : rd_addr_q);
    assign out_data   = out_valid ? fifo_data[rd_ptr_q[PW-1:0]] : '0;
    assign out_last   = out_valid && fifo_last_q[rd_ptr_q[PW-1:0]];
    assign done       = !reset && done_q;

    assign issue_last    = issue && (remaining_q == LEN_ONE);
    assign pipe_valid_in = {pipe_valid_q, issue};
    assign pipe_last_in  = {pipe_last_q, issue_last};
    assign fill          = pipe_valid_in[RD_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_ready = 1'b0;
        issue      = 1'b0;
        finish     = 1'b0;
        unique case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (cmd_valid && (cmd_len != '0)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if ((remaining_q != '0) && (credits_q < CREDIT_MAX)) begin
                    issue = 1'b1;
                    if (remaining_q == LEN_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as the final word pops so done lands the cycle after delivery.
                if ((credits_q == '0) || ((credits_q == CREDIT_ONE) && pop)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            rd_addr_q    <= '0;
            remaining_q  <= '0;
            credits_q    <= '0;
            pipe_valid_q <= '0;
            pipe_last_q  <= '0;
            fifo_last_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            done_q       <= 1'b0;
        end else begin
            if (accept) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_len;
            end else if (issue) begin
                addr_q      <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
                remaining_q <= remaining_q - LEN_ONE;
                rd_addr_q   <= addr_q;
            end
            credits_q    <= credits_q + CW'(issue) - CW'(pop);
            pipe_valid_q <= pipe_valid_in[RD_LATENCY-1:0];
            pipe_last_q  <= pipe_last_in[RD_LATENCY-1:0];
            if (fill) begin
                fifo_last_q[wr_ptr_q[PW-1:0]] <= pipe_last_in[RD_LATENCY];
                wr_ptr_q                      <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            done_q <= (accept && (cmd_len == '0)) || finish;
        end
    end

    // Payload storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (fill) begin
            fifo_data[wr_ptr_q[PW-1:0]] <= rd_data;
        end
    end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side engine for the simple dual-port RAM wrapper's synchronous read port (`rd_en`/`rd_addr`/`rd_data`, fixed read latency). It accepts a burst command (start address, word count), issues sequential reads with address wrap-around, and presents the returned words as a valid/ready stream with `last` marking. A credit-limited skid FIFO absorbs in-flight read data, so downstream backpressure never loses a word. It sits between any RAM-backed buffer (frame buffer, line buffer, packet store) and a streaming consumer.

## Interface
- `WORD_COUNT`, 640, RAM depth in words; addresses wrap from WORD_COUNT-1 to 0
- `ADDR_WIDTH`, 10, RAM address width, ≥ clog2(WORD_COUNT)
- `DATA_WIDTH`, 128, word width
- `LEN_WIDTH`, 11, burst length width (max burst 2^LEN_WIDTH-1)
- `RD_LATENCY`, 1, cycles from `rd_en` to valid `rd_data`; range 1..4
- `SKID_DEPTH`, 4, skid FIFO entries, power of two, ≥ RD_LATENCY+2 for full throughput
- `clk`  in  1  sole clock; RAM read port runs on it
- `reset`  in  1  synchronous, active-high
- `cmd_valid`  in  1  burst command offered
- `cmd_ready`  out  1  engine idle and accepting
- `cmd_addr`  in  ADDR_WIDTH  start address, < WORD_COUNT
- `cmd_len`  in  LEN_WIDTH  words to read; 0 allowed
- `rd_en`  out  1  RAM read strobe
- `rd_addr`  out  ADDR_WIDTH  RAM read address
- `rd_data`  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after `rd_en`
- `out_valid`  out  1  stream word available
- `out_ready`  in  1  consumer accepts
- `out_data`  out  DATA_WIDTH  stream word
- `out_last`  out  1  final word of burst
- `done`  out  1  one-cycle pulse when burst fully delivered

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch `cmd_addr` into address counter and `cmd_len` into remaining counter. If len=0 → stay IDLE, pulse `done` next cycle, no reads issued. Otherwise → ISSUE.
- ISSUE: `rd_en`=1 when remaining>0 and credits<SKID_DEPTH (credits = reads in flight + FIFO occupancy). On each issue: address increments, wrapping to 0 after WORD_COUNT-1; remaining decrements. When the last read issues → DRAIN.
- In-flight tracking: RD_LATENCY-deep shift register of issue flags plus a last-tag; a flag emerging writes `rd_data` and its tag into the FIFO that cycle.
- DRAIN: no reads. When in-flight=0, FIFO empty, and no pop pending → IDLE, `done` pulses for 1 cycle.
- Stream: `out_valid` = FIFO non-empty; pop on `out_valid && out_ready`. `out_data`/`out_last` held stable while `out_valid && !out_ready`. `out_last`=1 only on the word from the final read of a burst.
- `rd_addr` holds its last value while `rd_en`=0 (don't-care to RAM, but must not be X after reset).
- Credits update with simultaneous issue and pop in the same cycle: net 0 change; FIFO never overflows by construction.
- `cmd_addr` ≥ WORD_COUNT: undefined, not checked.

## Timing
- Reset (while `reset`=1 and first edge after): state IDLE, counters 0, FIFO empty, shift register cleared; `cmd_ready`=0 while `reset` high, `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `done`=0.
- Reset mid-burst: all in-flight and buffered data discarded; no `done`; next cycle behaves as post-reset.
- Command accepted at edge T: first `rd_en` at cycle T+1; data written to FIFO at T+1+RD_LATENCY; first `out_valid` at T+2+RD_LATENCY.
- `out_ready` held high and SKID_DEPTH ≥ RD_LATENCY+2: one word per cycle; N-word burst delivers its last word at T+1+RD_LATENCY+N; `done` the cycle after.
- `out_ready` low: issue stops once credits reach SKID_DEPTH; resumes the cycle after a pop.
- Next command accepted no earlier than the cycle `done` is high (`cmd_ready`=1 again in IDLE).

## Test plan
- RD_LATENCY=1, RAM word i = i, cmd addr=5 len=4, `out_ready`=1 → `rd_addr` 5,6,7,8 on consecutive cycles; out_data 5,6,7,8 back-to-back from T+3; `out_last` on 8 only; `done` one cycle after.
- Wrap: WORD_COUNT=640, addr=638 len=4 → `rd_addr` 638,639,0,1; data in the same order.
- Backpressure: RD_LATENCY=2, len=16, `out_ready` low for 10 cycles mid-burst → at most SKID_DEPTH=4 words in flight+buffered, all 16 words delivered in order, no duplicates, `out_data` stable while stalled.
- len=0 → no `rd_en`, no `out_valid`, `done` pulses once, `cmd_ready` stays 1.
- Reset asserted with 3 words buffered and 1 in flight → `out_valid`=0 next cycle, no `done`; a new burst addr=0 len=2 returns exactly words 0,1.
- Random bursts with random `out_ready` at RD_LATENCY 1..4 vs scoreboard → stream equals RAM contents per burst, one `out_last` and one `done` per nonzero burst.
